byte_stream_io: RTL and testbench

Memory-mapped byte-stream peripheral on the MSP430 peripheral bus for simulation and FPGA benches. It buffers bytes between the CPU and an external byte source/sink using two small FIFOs. The RX FIFO is filled from a valid/ready input stream and popped by CPU reads. The TX FIFO is pushed by CPU writes and drained to a valid/ready output stream. It is the streaming counterpart of the file I/O peripheral: the host-side file reader/writer connects to its stream ports instead of talking to the bus directly.

---
 rtl/byte_stream_io_pkg.sv | 23 ++
 rtl/byte_stream_io_if.sv | 24 ++
 rtl/byte_stream_io_fifo.sv | 51 +++++
 rtl/byte_stream_io.sv | 84 ++++++++
 tb/tb_byte_stream_io.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/byte_stream_io_pkg.sv
// Shared register map and status bit layout for the byte-stream peripheral.
package byte_stream_io_pkg;

   typedef enum logic [3:0] {
      OFF_STATUS = 4'd0,
      OFF_RXDATA = 4'd2,
      OFF_TXDATA = 4'd4,
      OFF_LEVEL  = 4'd6
   } reg_off_e;

   localparam int ST_RX_AVAIL = 0;
   localparam int ST_TX_SPACE = 1;
   localparam int ST_TX_OVF   = 2;
   localparam int ST_TX_EMPTY = 3;

   localparam logic [15:0] REG_ONEHOT_BASE = 16'h0001;

   // One-hot register select indexed by byte offset.
   function automatic logic [15:0] reg_onehot(input logic [3:0] off);
      return REG_ONEHOT_BASE << off;
   endfunction

endpackage

// File: rtl/byte_stream_io_if.sv
// Peripheral bus plus RX/TX byte streams of the byte-stream peripheral.
interface byte_stream_io_if;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport slave (
      input  per_addr, per_din, per_en, per_we, rx_data, rx_valid, tx_ready,
      output per_dout, rx_ready, tx_data, tx_valid
   );

   modport master (
      output per_addr, per_din, per_en, per_we, rx_data, rx_valid, tx_ready,
      input  per_dout, rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/byte_stream_io_fifo.sv
// Synchronous byte FIFO; push when full and pop when empty are ignored.
module sync_byte_fifo #(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push, w_pop;

   // Count never exceeds DEPTH, so its MSB alone flags full.
   assign full   = r_count[AW];
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = empty ? 8'h00 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/byte_stream_io.sv
// Memory-mapped byte-stream peripheral: bus decoder, tx_ovf flag and read mux
// around an RX FIFO (stream in, CPU pop) and a TX FIFO (CPU push, stream out).
module byte_stream_io
   import byte_stream_io_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR = 15'h00c8,
   parameter int          DEC_WD    = 3,
   parameter int          FIFO_AW   = 3
) (
   input  logic            mclk,
   input  logic            puc_rst_n,
   byte_stream_io_if.slave bus
);
   localparam int CW = FIFO_AW + 1;

   logic              w_sel, w_rd, w_wr;
   logic [DEC_WD-2:0] w_idx;
   logic [15:0]       w_reg;
   logic [15:0]       w_dout;
   logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ready;
   logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic [7:0]        w_rx_dout, w_tx_dout;
   logic [CW-1:0]     w_rx_count, w_tx_count;
   logic              w_ovf_set, w_ovf_clr;
   logic              r_tx_ovf;
   logic              w_unused;

   assign w_sel = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign w_idx = bus.per_addr[DEC_WD-2:0];
   assign w_reg = reg_onehot(4'({w_idx, 1'b0}));
   assign w_rd  = w_sel & (bus.per_we == 2'b00);
   assign w_wr  = w_sel & bus.per_we[0];
   assign w_unused = ^bus.per_din[15:8];

   assign w_rx_ready   = ~w_rx_full & puc_rst_n;
   assign bus.rx_ready = w_rx_ready;
   assign w_rx_push    = bus.rx_valid & w_rx_ready;
   assign w_rx_pop     = w_rd & w_reg[OFF_RXDATA];

   assign bus.tx_valid = ~w_tx_empty;
   assign bus.tx_data  = w_tx_dout;
   assign w_tx_push    = w_wr & w_reg[OFF_TXDATA];
   assign w_tx_pop     = ~w_tx_empty & bus.tx_ready;

   sync_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
      .clk(mclk), .rst_n(puc_rst_n), .push(w_rx_push), .pop(w_rx_pop),
      .din(bus.rx_data), .dout(w_rx_dout), .count(w_rx_count),
      .full(w_rx_full), .empty(w_rx_empty)
   );

   sync_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
      .clk(mclk), .rst_n(puc_rst_n), .push(w_tx_push), .pop(w_tx_pop),
      .din(bus.per_din[7:0]), .dout(w_tx_dout), .count(w_tx_count),
      .full(w_tx_full), .empty(w_tx_empty)
   );

   // Set beats clear when both land in the same cycle.
   assign w_ovf_set = w_tx_push & w_tx_full;
   assign w_ovf_clr = w_wr & w_reg[OFF_STATUS] & bus.per_din[ST_TX_OVF];

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n)     r_tx_ovf <= 1'b0;
      else if (w_ovf_set) r_tx_ovf <= 1'b1;
      else if (w_ovf_clr) r_tx_ovf <= 1'b0;
   end

   always_comb begin
      w_dout = '0;
      if (w_rd) begin
         if (w_reg[OFF_STATUS]) begin
            w_dout[ST_RX_AVAIL] = ~w_rx_empty;
            w_dout[ST_TX_SPACE] = ~w_tx_full;
            w_dout[ST_TX_OVF]   = r_tx_ovf;
            w_dout[ST_TX_EMPTY] = w_tx_empty;
         end else if (w_reg[OFF_RXDATA]) begin
            w_dout = {8'h00, w_rx_dout};
         end else if (w_reg[OFF_LEVEL]) begin
            w_dout = {8'(w_tx_count), 8'(w_rx_count)};
         end
      end
   end

   assign bus.per_dout = w_dout;
endmodule

// File: tb/tb_byte_stream_io.sv
// Self-checking bench for byte_stream_io: register vector table plus TX/RX scoreboards.
module tb_byte_stream_io;
   import byte_stream_io_pkg::*;

   logic mclk = 1'b0;
   logic puc_rst_n = 1'b0;
   int   vectors = 0;
   int   miscmp  = 0;

   byte_stream_io_if bus();

   byte_stream_io #(.BASE_ADDR(15'h00c8), .DEC_WD(3), .FIFO_AW(3)) dut (
      .mclk(mclk), .puc_rst_n(puc_rst_n), .bus(bus.slave)
   );

   always #5 mclk = ~mclk;

   typedef struct packed {
      logic        en;
      logic [3:0]  off;
      logic [1:0]  we;
      logic [15:0] din;
      logic        rxv;
      logic [7:0]  rxd;
      logic        chk;
      logic [15:0] exp;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       mon_stall = 1'b0;
   logic [7:0] mon_prev  = 8'h00;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] waddr(input logic [3:0] off);
      return 14'h0064 + 14'(off >> 1);
   endfunction

   function automatic void addv(input logic en, input logic [3:0] off, input logic [1:0] we,
                                input logic [15:0] din, input logic rxv, input logic [7:0] rxd,
                                input logic chk, input logic [15:0] exp);
      vq.push_back('{en, off, we, din, rxv, rxd, chk, exp});
   endfunction

   task automatic tick;
      @(posedge mclk);
      #1;
   endtask

   task automatic bus_set(input logic en, input logic [3:0] off, input logic [1:0] we, input logic [15:0] din);
      bus.per_en   = en;
      bus.per_addr = waddr(off);
      bus.per_we   = we;
      bus.per_din  = din;
   endtask

   task automatic bus_rd(input logic [3:0] off, output logic [15:0] d);
      bus_set(1'b1, off, 2'b00, 16'h0);
      @(negedge mclk);
      d = bus.per_dout;
      tick;
      bus_set(1'b0, OFF_STATUS, 2'b00, 16'h0);
   endtask

   task automatic bus_wr(input logic [3:0] off, input logic [15:0] din);
      bus_set(1'b1, off, 2'b01, din);
      tick;
      bus_set(1'b0, OFF_STATUS, 2'b00, 16'h0);
   endtask

   task automatic tx_drain(input string name);
      bus.tx_ready = 1'b1;
      for (int k = 0; k < 40 && bus.tx_valid; k++) tick;
      check({name, "_valid"}, 16'(bus.tx_valid), 16'h0);
      check({name, "_left"}, 16'(tx_q.size()), 16'h0);
   endtask

   // TX sink monitor: a transfer happens at the next rising edge.
   always @(negedge mclk) begin
      if (mon_stall && bus.tx_valid)
         check("tx_hold", {8'h00, bus.tx_data}, {8'h00, mon_prev});
      if (bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            vectors++;
            miscmp++;
            $display("FAIL tx_extra: got %h want no byte", bus.tx_data);
         end else begin
            check("tx_data", {8'h00, bus.tx_data}, {8'h00, tx_q.pop_front()});
         end
      end
      mon_stall = bus.tx_valid & ~bus.tx_ready;
      mon_prev  = bus.tx_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      bus_set(1'b0, OFF_STATUS, 2'b00, 16'h0);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b0;

      // Reset held for three cycles
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      check("rst_rx_ready", 16'(bus.rx_ready), 16'h0);
      check("rst_tx_valid", 16'(bus.tx_valid), 16'h0);
      check("rst_tx_data",  {8'h00, bus.tx_data}, 16'h0);
      check("rst_dout",     bus.per_dout, 16'h0);
      puc_rst_n = 1'b1;
      tick;

      // en off we din rxv rxd chk exp
      addv(1, OFF_STATUS, 2'b00, 16'h0,    0, 8'h00, 1, 16'h000A);
      addv(1, OFF_LEVEL,  2'b00, 16'h0,    0, 8'h00, 1, 16'h0000);
      addv(1, OFF_TXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0000);
      addv(0, OFF_STATUS, 2'b00, 16'h0,    1, 8'h41, 0, 16'h0000);
      addv(0, OFF_STATUS, 2'b00, 16'h0,    1, 8'h42, 0, 16'h0000);
      addv(0, OFF_STATUS, 2'b00, 16'h0,    1, 8'h43, 0, 16'h0000);
      addv(1, OFF_LEVEL,  2'b00, 16'h0,    0, 8'h00, 1, 16'h0003);
      addv(1, OFF_STATUS, 2'b00, 16'h0,    0, 8'h00, 1, 16'h000B);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0041);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0042);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0043);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0000);
      addv(1, OFF_STATUS, 2'b00, 16'h0,    0, 8'h00, 1, 16'h000A);
      addv(1, OFF_TXDATA, 2'b10, 16'h0077, 0, 8'h00, 0, 16'h0000);
      addv(1, OFF_LEVEL,  2'b00, 16'h0,    0, 8'h00, 1, 16'h0000);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    1, 8'h99, 1, 16'h0000);
      addv(1, OFF_RXDATA, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0099);
      addv(0, OFF_STATUS, 2'b00, 16'h0,    0, 8'h00, 1, 16'h0000);

      foreach (vq[i]) begin
         bus_set(vq[i].en, vq[i].off, vq[i].we, vq[i].din);
         bus.rx_valid = vq[i].rxv;
         bus.rx_data  = vq[i].rxd;
         @(negedge mclk);
         if (vq[i].chk) check($sformatf("vec%0d", i), bus.per_dout, vq[i].exp);
         tick;
      end
      bus_set(1'b0, OFF_STATUS, 2'b00, 16'h0);
      bus.rx_valid = 1'b0;

      // RX full: 10 offered, 8 accepted
      for (int i = 0; i < 10; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'h50 + 8'(i);
         if (i < 8) rx_q.push_back(8'h50 + 8'(i));
         @(negedge mclk);
         check($sformatf("rx_ready%0d", i), 16'(bus.rx_ready), (i < 8) ? 16'h1 : 16'h0);
         tick;
      end
      bus.rx_data = 8'h5A;
      bus_rd(OFF_RXDATA, d);
      check("rxfull_rd", d, {8'h00, rx_q.pop_front()});
      tick;
      rx_q.push_back(8'h5A);
      bus.rx_valid = 1'b0;
      bus_rd(OFF_LEVEL, d);
      check("rxfull_level", d, 16'h0008);
      for (int i = 0; i < 8; i++) begin
         bus_rd(OFF_RXDATA, d);
         check("rx_drain", d, {8'h00, rx_q.pop_front()});
      end
      bus_rd(OFF_STATUS, d);
      check("rx_empty_status", d, 16'h000A);

      // TX overflow with sink stalled
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus_wr(OFF_TXDATA, 16'h0010 + 16'(i));
         if (i < 8) tx_q.push_back(8'h10 + 8'(i));
      end
      bus_rd(OFF_LEVEL, d);
      check("ovf_level", d, 16'h0800);
      bus_rd(OFF_STATUS, d);
      check("ovf_status", d, 16'h0004);
      bus_wr(OFF_STATUS, 16'h0004);
      bus_rd(OFF_STATUS, d);
      check("ovf_cleared", d, 16'h0000);
      tx_drain("ovf_drain");
      bus_rd(OFF_STATUS, d);
      check("ovf_after_drain", d, 16'h000A);

      // TX backpressure: tx_ready toggles each cycle
      for (int i = 0; i < 12; i++) begin
         bus.tx_ready = i[0];
         bus_wr(OFF_TXDATA, 16'h0060 + 16'(i));
         tx_q.push_back(8'h60 + 8'(i));
      end
      tx_drain("bp_drain");

      // Reset mid-operation with 5 RX and 4 TX bytes buffered
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'h70 + 8'(i);
         tick;
      end
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) bus_wr(OFF_TXDATA, 16'h0080 + 16'(i));
      bus_rd(OFF_LEVEL, d);
      check("pre_rst_level", d, 16'h0405);
      bus_set(1'b1, OFF_LEVEL, 2'b00, 16'h0);
      @(negedge mclk);
      #1;
      puc_rst_n = 1'b0;
      #1;
      check("mid_rst_level",    bus.per_dout, 16'h0000);
      check("mid_rst_tx_valid", 16'(bus.tx_valid), 16'h0);
      check("mid_rst_rx_ready", 16'(bus.rx_ready), 16'h0);
      bus_set(1'b1, OFF_STATUS, 2'b00, 16'h0);
      #1;
      check("mid_rst_status", bus.per_dout, 16'h000A);
      puc_rst_n = 1'b1;
      tick;
      bus_rd(OFF_LEVEL, d);
      check("post_rst_level", d, 16'h0000);
      bus_rd(OFF_RXDATA, d);
      check("post_rst_rxdata", d, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
endmodule
